instr_mem_resp: RTL and testbench
=================================

Name: instr_mem_resp

Overview:
Program-memory responder: the slave end of the PM fetch interface (pm_rd/pm_addr/pm_ready/pm_instr_valid/pm_instr).
- Holds the instruction image in an on-chip synchronous RAM.
- Inserts a configurable number of wait states per access.
- Returns each instruction exactly one cycle after acceptance.
- Provides a word-write load port used by the boot loader / testbench to fill the image before and between runs.

Parameters:
- XLEN, 32, instruction/data width; word = XLEN/8 bytes, ALIGN = log2(XLEN/8).
- DEPTH_WORDS, 1024, number of instruction words; power of two.
- WAIT_STATES, 0, extra cycles pm_ready_o is held low per access (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be word aligned.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pm_rd_i  in  1  read request from the fetch unit.
- pm_addr_i  in  XLEN  byte address of the requested instruction.
- pm_ready_o  out  1  request accepted this cycle (pm_rd_i & pm_ready_o).
- pm_instr_valid_o  out  1  response valid; one cycle after acceptance.
- pm_instr_o  out  XLEN  instruction word.
- pm_err_o  out  1  response is an error (misaligned or out of range); qualified by pm_instr_valid_o.
- ld_we_i  in  1  load-port write strobe.
- ld_addr_i  in  XLEN  load byte address; same map and alignment rules as pm_addr_i.
- ld_data_i  in  XLEN  load write data.

Behaviour:
- Reset values (asynchronous, rst_i=1): state IDLE, wait counter 0, pm_instr_valid_o=0, pm_instr_o=0, pm_err_o=0. pm_ready_o is forced 0 while rst_i=1. RAM contents are not reset.
- Word index: idx = (addr - BASE_ADDR) >> ALIGN.
  - in_range = (addr >= BASE_ADDR) && (idx < DEPTH_WORDS); compare at full XLEN width, no wrap.
  - aligned = addr[ALIGN-1:0] == 0.
- FSM states IDLE and WAIT; counter cnt is 4 bits.
  - IDLE, WAIT_STATES=0: pm_ready_o = pm_rd_i & ~ld_we_i. Accept in the same cycle.
  - IDLE, WAIT_STATES>0, pm_rd_i=1, ld_we_i=0: go to WAIT with cnt=WAIT_STATES-1, latch the address; pm_ready_o=0.
  - WAIT, cnt>0: decrement cnt; pm_ready_o=0.
  - WAIT, cnt==0, pm_rd_i=1: pm_ready_o=1 (accept), return to IDLE. Every access pays the full WAIT_STATES, including back-to-back accesses.
  - WAIT, pm_rd_i=0 (requester stalled): abort, return to IDLE, no response.
  - WAIT, pm_addr_i differs from the latched address: restart with cnt=WAIT_STATES-1.
  - ld_we_i=1 in any state: pm_ready_o=0 and cnt frozen; the load write has priority.
- Acceptance (pm_rd_i & pm_ready_o): issue a synchronous RAM read. In the next cycle:
  - pm_instr_valid_o=1;
  - pm_instr_o = mem[idx];
  - pm_err_o=0.
  - If the address was misaligned or out of range: pm_instr_o=0 (illegal instruction), pm_err_o=1, no RAM read.
  - Throughput is one accept per cycle when WAIT_STATES=0.
- In any cycle without a response: pm_instr_valid_o=0, pm_instr_o holds its last value, pm_err_o=0.
- Load port:
  - ld_we_i with in-range, aligned ld_addr_i writes mem[idx] at the clock edge.
  - Invalid ld_addr_i: write silently dropped.
- Read/write ordering:
  - Write to the address accepted in the previous cycle: the response carries old data.
  - Reads accepted after the write cycle see new data.
- Reset mid-operation: any pending response is discarded (pm_instr_valid_o=0 after reset) and the FSM returns to IDLE. Stored words are retained.

Optional Feature:
- Macro: INSTR_MEM_PERF_CNT_EN.
- Defined: adds outputs perf_reads_o [31:0] and perf_wait_o [31:0].
  - perf_reads_o counts accepted reads, including error reads.
  - perf_wait_o counts cycles with pm_rd_i=1 & pm_ready_o=0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0 on rst_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package instr_mem_pkg:
  - state enum (IDLE, WAIT);
  - ERR_INSTR constant (XLEN'h0);
  - CNT_W=4;
  - function for address decode (idx/in_range/aligned).
- Sub-module instr_mem_array: 1R1W synchronous RAM, DEPTH_WORDS x XLEN, with registered read.

Test Plan:
- Load 0x00000013 @0x0 and 0x00100093 @0x4; WAIT_STATES=0; hold pm_rd_i=1 with addr 0x0 then 0x4 → pm_ready_o=1 both cycles; valid responses 0x00000013 then 0x00100093 in the following cycles; pm_err_o=0.
- WAIT_STATES=2; request 0x4 held → pm_ready_o low for 2 cycles, high on the 3rd; response the next cycle; perf_wait_o=2 and perf_reads_o=1 if the macro is defined.
- WAIT_STATES=2; drop pm_rd_i after 1 cycle, then re-request 0x8 → no response for the aborted request; 0x8 waits the full 2 cycles.
- Request 0x2 (misaligned) and 0x1000 (DEPTH_WORDS=1024, out of range) → each accepted; response pm_instr_o=0, pm_err_o=1.
- ld_we_i=1 writing 0xDEADBEEF @0x0 concurrently with pm_rd_i @0x0 → pm_ready_o=0 that cycle; next-cycle accept returns 0xDEADBEEF.
- Assert rst_i for one cycle immediately after an acceptance → pm_instr_valid_o stays 0; re-request after reset returns the previously loaded word.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and address decode for the program-memory responder
package instr_mem_pkg;

  localparam int CNT_W    = 4;
  localparam int XLEN_MAX = 64;

  localparam logic [XLEN_MAX-1:0] ERR_INSTR = '0;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] idx;
    logic                in_range;
    logic                aligned;
  } addr_dec_t;

  // Operands are zero-extended to XLEN_MAX so the range check never wraps.
  function automatic addr_dec_t addr_decode(input logic [XLEN_MAX-1:0] addr,
                                            input logic [XLEN_MAX-1:0] base,
                                            input int align,
                                            input int depth);
    addr_dec_t           res;
    logic [XLEN_MAX-1:0] mask;
    res.idx      = (addr - base) >> align;
    res.in_range = (addr >= base) && (res.idx < XLEN_MAX'(depth));
    mask         = (XLEN_MAX'(1) << align) - XLEN_MAX'(1);
    res.aligned  = (addr & mask) == '0;
    return res;
  endfunction

endpackage

// File: rtl/instr_mem_resp_if.sv
// rtl/instr_mem_resp_if.sv - PM fetch bus plus boot-loader word-write port
interface instr_mem_resp_if #(
  parameter int XLEN = 32
);
  logic            pm_rd_i;
  logic [XLEN-1:0] pm_addr_i;
  logic            pm_ready_o;
  logic            pm_instr_valid_o;
  logic [XLEN-1:0] pm_instr_o;
  logic            pm_err_o;
  logic            ld_we_i;
  logic [XLEN-1:0] ld_addr_i;
  logic [XLEN-1:0] ld_data_i;

  modport master (
    output pm_rd_i, pm_addr_i, ld_we_i, ld_addr_i, ld_data_i,
    input  pm_ready_o, pm_instr_valid_o, pm_instr_o, pm_err_o
  );

  modport slave (
    input  pm_rd_i, pm_addr_i, ld_we_i, ld_addr_i, ld_data_i,
    output pm_ready_o, pm_instr_valid_o, pm_instr_o, pm_err_o
  );
endinterface

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - 1R1W synchronous RAM with registered read, contents not reset
module instr_mem_array #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_resp.sv
// rtl/instr_mem_resp.sv - PM fetch responder with wait states; INSTR_MEM_PERF_CNT_EN adds perf counters
module instr_mem_resp
  import instr_mem_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter int              WAIT_STATES = 0,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_mem_resp_if.slave       bus
`ifdef INSTR_MEM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_reads_o,
  output logic [31:0]           perf_wait_o
`endif
);

  localparam int ALIGN = $clog2(XLEN / 8);
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WS_M1 = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] lat_addr;
  logic            ready;
  logic            accept;
  logic            valid_q;
  logic            err_q;
  logic [XLEN-1:0] hold_q;
  logic [XLEN-1:0] ram_rdata;
  logic [XLEN-1:0] instr_out;
  addr_dec_t       rd_dec;
  addr_dec_t       ld_dec;
  logic            rd_ok;
  logic            ld_ok;
  logic            unused_idx_bits;

  assign rd_dec = addr_decode(XLEN_MAX'(bus.pm_addr_i), XLEN_MAX'(BASE_ADDR), ALIGN, DEPTH_WORDS);
  assign ld_dec = addr_decode(XLEN_MAX'(bus.ld_addr_i), XLEN_MAX'(BASE_ADDR), ALIGN, DEPTH_WORDS);
  assign rd_ok  = rd_dec.in_range & rd_dec.aligned;
  assign ld_ok  = ld_dec.in_range & ld_dec.aligned;
  assign unused_idx_bits = ^{rd_dec.idx[XLEN_MAX-1:AW], ld_dec.idx[XLEN_MAX-1:AW]};

  // Load writes always win; with wait states, accept only once the counted address is still presented.
  always_comb begin
    ready = 1'b0;
    if (!rst_i && !bus.ld_we_i && bus.pm_rd_i) begin
      if (WAIT_STATES == 0) begin
        ready = 1'b1;
      end else begin
        ready = (state == WAIT) && (cnt == '0) && (bus.pm_addr_i == lat_addr);
      end
    end
  end

  assign bus.pm_ready_o = ready;
  assign accept         = bus.pm_rd_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
    end else if (WAIT_STATES != 0 && !bus.ld_we_i) begin
      case (state)
        IDLE: begin
          if (bus.pm_rd_i) begin
            state    <= WAIT;
            cnt      <= WS_M1;
            lat_addr <= bus.pm_addr_i;
          end
        end
        WAIT: begin
          if (!bus.pm_rd_i) begin
            state <= IDLE;
          end else if (bus.pm_addr_i != lat_addr) begin
            cnt      <= WS_M1;
            lat_addr <= bus.pm_addr_i;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_mem_array #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i (clk_i),
    .we    (bus.ld_we_i & ld_ok),
    .waddr (ld_dec.idx[AW-1:0]),
    .wdata (bus.ld_data_i),
    .re    (accept & rd_ok),
    .raddr (rd_dec.idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= accept;
      err_q   <= accept & ~rd_ok;
      if (valid_q) begin
        hold_q <= instr_out;
      end
    end
  end

  // The RAM output register only updates on reads, so hold_q keeps the last response visible.
  assign instr_out = !valid_q ? hold_q :
                     err_q    ? ERR_INSTR[XLEN-1:0] : ram_rdata;

  assign bus.pm_instr_valid_o = valid_q;
  assign bus.pm_instr_o       = instr_out;
  assign bus.pm_err_o         = err_q;

`ifdef INSTR_MEM_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_reads_o <= '0;
      perf_wait_o  <= '0;
    end else begin
      if (accept && perf_reads_o != 32'hFFFF_FFFF) begin
        perf_reads_o <= perf_reads_o + 32'd1;
      end
      if (bus.pm_rd_i && !ready && perf_wait_o != 32'hFFFF_FFFF) begin
        perf_wait_o <= perf_wait_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_resp.sv
// tb/tb_instr_mem_resp.sv - directed bench for instr_mem_resp with zero and two wait states
module tb_instr_mem_resp;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  instr_mem_resp_if #(.XLEN(32)) if0 ();
  instr_mem_resp_if #(.XLEN(32)) if2 ();

  assign if2.ld_we_i   = if0.ld_we_i;
  assign if2.ld_addr_i = if0.ld_addr_i;
  assign if2.ld_data_i = if0.ld_data_i;

`ifdef INSTR_MEM_PERF_CNT_EN
  logic [31:0] p0_reads, p0_wait, p2_reads, p2_wait;
`endif

  instr_mem_resp #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
`ifdef INSTR_MEM_PERF_CNT_EN
    ,
    .perf_reads_o (p0_reads),
    .perf_wait_o  (p0_wait)
`endif
  );

  instr_mem_resp #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if2.slave)
`ifdef INSTR_MEM_PERF_CNT_EN
    ,
    .perf_reads_o (p2_reads),
    .perf_wait_o  (p2_wait)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst           = 1'b1;
    if0.pm_rd_i   = 1'b1;
    if0.pm_addr_i = 32'h0;
    if2.pm_rd_i   = 1'b0;
    if2.pm_addr_i = 32'h0;
    if0.ld_we_i   = 1'b0;
    if0.ld_addr_i = 32'h0;
    if0.ld_data_i = 32'h0;
    #2;
    chk("rst_ready",  {31'd0, if0.pm_ready_o}, 32'd0);
    chk("rst_valid",  {31'd0, if0.pm_instr_valid_o}, 32'd0);
    chk("rst_instr",  if0.pm_instr_o, 32'h0);
    chk("rst_err",    {31'd0, if0.pm_err_o}, 32'd0);
    chk("rst_valid2", {31'd0, if2.pm_instr_valid_o}, 32'd0);

    tick();
    rst         = 1'b0;
    if0.pm_rd_i = 1'b0;
    if0.ld_we_i = 1'b1; if0.ld_addr_i = 32'h0; if0.ld_data_i = 32'h0000_0013;
    tick();
    if0.ld_addr_i = 32'h4; if0.ld_data_i = 32'h0010_0093;
    tick();
    if0.ld_addr_i = 32'h8; if0.ld_data_i = 32'h8888_0008;
    tick();
    if0.ld_addr_i = 32'h2; if0.ld_data_i = 32'hBAD0_BAD0;
    tick();
    if0.ld_addr_i = 32'h1000; if0.ld_data_i = 32'hBAD1_BAD1;
    tick();
    if0.ld_we_i = 1'b0;

    // Back-to-back fetches, no wait states
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h0;
    settle();
    chk("b2b_ready0", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    if0.pm_addr_i = 32'h4;
    settle();
    chk("b2b_ready1", {31'd0, if0.pm_ready_o}, 32'd1);
    chk("b2b_valid0", {31'd0, if0.pm_instr_valid_o}, 32'd1);
    chk("b2b_instr0", if0.pm_instr_o, 32'h0000_0013);
    chk("b2b_err0",   {31'd0, if0.pm_err_o}, 32'd0);
    tick();
    if0.pm_rd_i = 1'b0;
    settle();
    chk("b2b_valid1", {31'd0, if0.pm_instr_valid_o}, 32'd1);
    chk("b2b_instr1", if0.pm_instr_o, 32'h0010_0093);
    tick();
    settle();
    chk("idle_valid", {31'd0, if0.pm_instr_valid_o}, 32'd0);
    chk("idle_hold",  if0.pm_instr_o, 32'h0010_0093);

    // Two wait states, request held
    if2.pm_rd_i = 1'b1; if2.pm_addr_i = 32'h4;
    settle();
    chk("ws_ready_c0", {31'd0, if2.pm_ready_o}, 32'd0);
    tick();
    settle();
    chk("ws_ready_c1", {31'd0, if2.pm_ready_o}, 32'd0);
    tick();
    settle();
    chk("ws_ready_c2", {31'd0, if2.pm_ready_o}, 32'd1);
    tick();
    if2.pm_rd_i = 1'b0;
    settle();
    chk("ws_valid", {31'd0, if2.pm_instr_valid_o}, 32'd1);
    chk("ws_instr", if2.pm_instr_o, 32'h0010_0093);
    chk("ws_err",   {31'd0, if2.pm_err_o}, 32'd0);
`ifdef INSTR_MEM_PERF_CNT_EN
    chk("perf_wait",  p2_wait, 32'd2);
    chk("perf_reads", p2_reads, 32'd1);
`endif

    // Abort after one cycle, then a fresh request pays the full wait
    tick();
    if2.pm_rd_i = 1'b1; if2.pm_addr_i = 32'h0;
    settle();
    chk("abort_ready", {31'd0, if2.pm_ready_o}, 32'd0);
    tick();
    if2.pm_rd_i = 1'b0;
    settle();
    chk("abort_valid0", {31'd0, if2.pm_instr_valid_o}, 32'd0);
    tick();
    if2.pm_rd_i = 1'b1; if2.pm_addr_i = 32'h8;
    settle();
    chk("abort_valid1", {31'd0, if2.pm_instr_valid_o}, 32'd0);
    chk("re_ready_c0",  {31'd0, if2.pm_ready_o}, 32'd0);
    tick();
    settle();
    chk("re_ready_c1", {31'd0, if2.pm_ready_o}, 32'd0);
    chk("re_valid_c1", {31'd0, if2.pm_instr_valid_o}, 32'd0);
    tick();
    settle();
    chk("re_ready_c2", {31'd0, if2.pm_ready_o}, 32'd1);
    tick();
    if2.pm_rd_i = 1'b0;
    settle();
    chk("re_valid", {31'd0, if2.pm_instr_valid_o}, 32'd1);
    chk("re_instr", if2.pm_instr_o, 32'h8888_0008);

    // Misaligned and out-of-range fetches
    tick();
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h2;
    settle();
    chk("mis_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    if0.pm_addr_i = 32'h1000;
    settle();
    chk("oor_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    chk("mis_valid", {31'd0, if0.pm_instr_valid_o}, 32'd1);
    chk("mis_instr", if0.pm_instr_o, 32'h0);
    chk("mis_err",   {31'd0, if0.pm_err_o}, 32'd1);
    tick();
    if0.pm_addr_i = 32'h0;
    settle();
    chk("oor_valid", {31'd0, if0.pm_instr_valid_o}, 32'd1);
    chk("oor_instr", if0.pm_instr_o, 32'h0);
    chk("oor_err",   {31'd0, if0.pm_err_o}, 32'd1);
    tick();
    if0.pm_rd_i = 1'b0;
    settle();
    chk("drop_ld_instr", if0.pm_instr_o, 32'h0000_0013);
    chk("drop_ld_err",   {31'd0, if0.pm_err_o}, 32'd0);
    tick();
    settle();
    chk("post_err_idle", {31'd0, if0.pm_err_o}, 32'd0);

    // Load write collides with a fetch of the same word
    if0.ld_we_i = 1'b1; if0.ld_addr_i = 32'h0; if0.ld_data_i = 32'hDEAD_BEEF;
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h0;
    settle();
    chk("ld_block_ready", {31'd0, if0.pm_ready_o}, 32'd0);
    tick();
    if0.ld_we_i = 1'b0;
    settle();
    chk("ld_after_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    if0.pm_rd_i = 1'b0;
    settle();
    chk("ld_new_instr", if0.pm_instr_o, 32'hDEAD_BEEF);

    // Write right after acceptance: response carries old data, later reads see new
    tick();
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h4;
    settle();
    chk("raw_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    if0.pm_rd_i = 1'b0;
    if0.ld_we_i = 1'b1; if0.ld_addr_i = 32'h4; if0.ld_data_i = 32'h4444_4444;
    settle();
    chk("raw_old", if0.pm_instr_o, 32'h0010_0093);
    tick();
    if0.ld_we_i = 1'b0;
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h4;
    settle();
    tick();
    if0.pm_rd_i = 1'b0;
    settle();
    chk("raw_new", if0.pm_instr_o, 32'h4444_4444);

    // Reset straight after an acceptance discards the response, keeps memory
    tick();
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h8;
    settle();
    chk("rst_acc_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    rst         = 1'b1;
    if0.pm_rd_i = 1'b0;
    settle();
    chk("rst_mid_valid", {31'd0, if0.pm_instr_valid_o}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_post_valid", {31'd0, if0.pm_instr_valid_o}, 32'd0);
    chk("rst_post_instr", if0.pm_instr_o, 32'h0);
    tick();
    if0.pm_rd_i = 1'b1; if0.pm_addr_i = 32'h8;
    settle();
    chk("rst_re_ready", {31'd0, if0.pm_ready_o}, 32'd1);
    tick();
    if0.pm_rd_i = 1'b0;
    settle();
    chk("rst_re_valid", {31'd0, if0.pm_instr_valid_o}, 32'd1);
    chk("rst_re_instr", if0.pm_instr_o, 32'h8888_0008);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
